regfile_sb: RTL and testbench

Parametrised multi-port register file with a per-register scoreboard, the next-generation register file for the processor datapath. It offers NRD combinational read ports, one single-cycle write port for ALU results and one completion write port for long-latency results such as loads. It also provides a reserve handshake that marks destination registers busy until their completion write arrives. Issue logic uses the busy flags, the pending count and the sticky error flag to stall on RAW/WAW hazards.

---
 rtl/regf_pkg.sv | 28 ++
 rtl/regf_scoreboard.sv | 85 ++++++++
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regf_pkg
// Brief    : Shared defaults, address-width helpers and types for regfile_sb.
// Revision : 1.0 - initial release
// ============================================================================
package regf_pkg;

  localparam int c_def_width = 16;
  localparam int c_def_depth = 8;
  localparam int c_def_nrd   = 2;

  function automatic int aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Address width is derived so that non-power-of-two depths still work.
  function automatic logic addr_ok(input int unsigned a, input int unsigned depth);
    return a < depth;
  endfunction

  localparam int c_def_aw = aw(c_def_depth);

  typedef logic [c_def_aw-1:0]    addr_t;
  typedef logic [c_def_width-1:0] data_t;

endpackage
`default_nettype wire

// File: rtl/regf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regf_scoreboard
// Brief    : Busy bits, pending count, reserve handshake and sticky error.
//            REGF_BYPASS_EN makes rbusy reflect a same-cycle completion.
// Revision : 1.0 - initial release
// ============================================================================
module regf_scoreboard import regf_pkg::*; #(
  parameter int DEPTH = c_def_depth,
  parameter int NRD   = c_def_nrd,
  parameter int AW    = aw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD-1:0][AW-1:0] rad,
  output logic [NRD-1:0]         rbusy,
  input  logic                   we0,
  input  logic [AW-1:0]          wad0,
  input  logic                   rsv_valid,
  input  logic [AW-1:0]          rsv_ad,
  output logic                   rsv_ready,
  input  logic                   we1,
  input  logic [AW-1:0]          wad1,
  input  logic                   flush,
  output logic [AW:0]            pend_cnt,
  output logic                   err
);

  localparam logic [AW:0] c_one = (AW+1)'(1);

  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_pend;
  logic             r_err;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_hit1;
  logic             w_accept;
  logic             w_clear;
  logic             w_err_set;

  assign w_hit1   = we1 & addr_ok(32'(wad1), DEPTH);
  // A completion landing on the reserved register frees it in the same cycle.
  assign w_accept = rsv_valid & ~flush & addr_ok(32'(rsv_ad), DEPTH) &
                    (~r_busy[rsv_ad] | (w_hit1 & (wad1 == rsv_ad)));
  assign w_clear  = w_hit1 & r_busy[wad1];
  assign w_err_set = (w_hit1 & ~flush & ~r_busy[wad1]) |
                     (we0 & addr_ok(32'(wad0), DEPTH) & r_busy[wad0]);

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clear)  w_busy_nxt[wad1]   = 1'b0;
    if (w_accept) w_busy_nxt[rsv_ad] = 1'b1;
    if (flush)    w_busy_nxt         = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush)                    r_pend <= '0;
      else if (w_accept & ~w_clear) r_pend <= r_pend + c_one;
      else if (w_clear & ~w_accept) r_pend <= r_pend - c_one;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rbusy
    logic w_b;
    assign w_b = addr_ok(32'(rad[i]), DEPTH) & r_busy[rad[i]];
`ifdef REGF_BYPASS_EN
    assign rbusy[i] = w_b & ~(w_clear & (wad1 == rad[i]) &
                              ~(w_accept & (rsv_ad == rad[i])));
`else
    assign rbusy[i] = w_b;
`endif
  end

  assign rsv_ready = w_accept;
  assign pend_cnt  = r_pend;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Multi-port register file with per-register scoreboard.
//            REGF_BYPASS_EN forwards same-cycle write data to the read ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb import regf_pkg::*; #(
  parameter int WIDTH = c_def_width,
  parameter int DEPTH = c_def_depth,
  parameter int NRD   = c_def_nrd,
  parameter int AW    = aw(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NRD-1:0][AW-1:0]    rad,
  output logic [NRD-1:0][WIDTH-1:0] rdata,
  output logic [NRD-1:0]            rbusy,
  input  logic                      we0,
  input  logic [AW-1:0]             wad0,
  input  logic [WIDTH-1:0]          wd0,
  input  logic                      rsv_valid,
  input  logic [AW-1:0]             rsv_ad,
  output logic                      rsv_ready,
  input  logic                      we1,
  input  logic [AW-1:0]             wad1,
  input  logic [WIDTH-1:0]          wd1,
  input  logic                      flush,
  output logic [AW:0]               pend_cnt,
  output logic                      err
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_we0;
  logic             w_we1;

  assign w_we0 = we0 & addr_ok(32'(wad0), DEPTH);
  assign w_we1 = we1 & addr_ok(32'(wad1), DEPTH);

  // we0 is written last so the younger ALU result wins a same-address clash.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (w_we1) r_mem[wad1] <= wd1;
      if (w_we0) r_mem[wad0] <= wd0;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [WIDTH-1:0] w_data;
    always_comb begin
      w_data = '0;
      if (addr_ok(32'(rad[i]), DEPTH)) w_data = r_mem[rad[i]];
`ifdef REGF_BYPASS_EN
      if (w_we1 && (wad1 == rad[i])) w_data = wd1;
      if (w_we0 && (wad0 == rad[i])) w_data = wd0;
`endif
    end
    assign rdata[i] = w_data;
  end

  regf_scoreboard #(
    .DEPTH (DEPTH),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rad       (rad),
    .rbusy     (rbusy),
    .we0       (we0),
    .wad0      (wad0),
    .rsv_valid (rsv_valid),
    .rsv_ad    (rsv_ad),
    .rsv_ready (rsv_ready),
    .we1       (we1),
    .wad1      (wad1),
    .flush     (flush),
    .pend_cnt  (pend_cnt),
    .err       (err)
  );

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Scoreboard bench for regfile_sb against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
  import regf_pkg::*;

  localparam int WIDTH = c_def_width;
  localparam int DEPTH = c_def_depth;
  localparam int NRD   = c_def_nrd;
  localparam int AW    = c_def_aw;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NRD-1:0][AW-1:0]    rad;
  logic [NRD-1:0][WIDTH-1:0] rdata;
  logic [NRD-1:0]            rbusy;
  logic                      we0, we1, rsv_valid, flush;
  logic [AW-1:0]             wad0, wad1, rsv_ad;
  logic [WIDTH-1:0]          wd0, wd1;
  logic                      rsv_ready;
  logic [AW:0]               pend_cnt;
  logic                      err;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD), .AW(AW)) dut (
    .clk(clk), .rst(rst), .rad(rad), .rdata(rdata), .rbusy(rbusy),
    .we0(we0), .wad0(wad0), .wd0(wd0),
    .rsv_valid(rsv_valid), .rsv_ad(rsv_ad), .rsv_ready(rsv_ready),
    .we1(we1), .wad1(wad1), .wd1(wd1),
    .flush(flush), .pend_cnt(pend_cnt), .err(err)
  );

  typedef struct {
    logic [NRD-1:0][WIDTH-1:0] rdata;
    logic [NRD-1:0]            rbusy;
    logic                      rsv_ready;
    logic [AW:0]               pend;
    logic                      err;
  } exp_t;

  exp_t  q[$];
  data_t m_reg [DEPTH];
  bit    m_busy[DEPTH];
  bit    m_err;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; wad0 = '0; wd0 = '0;
    we1 = 1'b0; wad1 = '0; wd1 = '0;
    rsv_valid = 1'b0; rsv_ad = '0; flush = 1'b0;
    for (int i = 0; i < NRD; i++) rad[i] = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_reg[k]  = '0;
      m_busy[k] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, then
  // advance the model and move to the next cycle.
  task automatic step();
    exp_t  e;
    bit    acc;
    int    cnt;
    addr_t a;
    data_t d;
    bit    b;
    acc = rsv_valid && !flush && (!m_busy[rsv_ad] || (we1 && wad1 == rsv_ad));
    for (int i = 0; i < NRD; i++) begin
      a = rad[i];
      d = m_reg[a];
      b = m_busy[a];
`ifdef REGF_BYPASS_EN
      if (we0 && wad0 == a) d = wd0;
      else if (we1 && wad1 == a) d = wd1;
      if (we1 && wad1 == a && !(acc && rsv_ad == a)) b = 1'b0;
`endif
      e.rdata[i] = d;
      e.rbusy[i] = b;
    end
    cnt = 0;
    for (int k = 0; k < DEPTH; k++) cnt += int'(m_busy[k]);
    e.rsv_ready = acc;
    e.pend      = (AW+1)'(cnt);
    e.err       = m_err;
    q.push_back(e);

    if ((we1 && !flush && !m_busy[wad1]) || (we0 && m_busy[wad0])) m_err = 1'b1;
    if (we1) m_reg[wad1] = wd1;
    if (we0) m_reg[wad0] = wd0;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) m_busy[k] = 1'b0;
    end else begin
      if (we1) m_busy[wad1] = 1'b0;
      if (acc) m_busy[rsv_ad] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < NRD; i++) begin
        chk($sformatf("rdata[%0d]", i), 32'(rdata[i]), 32'(e.rdata[i]));
        chk($sformatf("rbusy[%0d]", i), 32'(rbusy[i]), 32'(e.rbusy[i]));
      end
      chk("rsv_ready", 32'(rsv_ready), 32'(e.rsv_ready));
      chk("pend_cnt", 32'(pend_cnt), 32'(e.pend));
      chk("err", 32'(err), 32'(e.err));
    end
  end

  // Asynchronous reset with checks made before any clock edge arrives.
  task automatic async_reset();
    idle();
    rad[0] = 3; rad[1] = 5; rsv_valid = 1'b1; rsv_ad = 5;
    rst = 1'b0;
    #1;
    chk("rst_rdata0", 32'(rdata[0]), 32'h0);
    chk("rst_rdata1", 32'(rdata[1]), 32'h0);
    chk("rst_rbusy1", 32'(rbusy[1]), 32'h0);
    chk("rst_pend", 32'(pend_cnt), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rsv_ready", 32'(rsv_ready), 32'h1);
    #1;
    idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic reserve(input int r);
    idle(); rsv_valid = 1'b1; rsv_ad = AW'(r); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    model_reset();
    #1;
    async_reset();

    // reserve then load
    reserve(2);
    idle(); rad[0] = 2; step();
    rsv_valid = 1'b1; rsv_ad = 2; step();
    idle(); rad[0] = 2; we1 = 1'b1; wad1 = 2; wd1 = 16'hBEEF; step();
    idle(); rad[0] = 2; step();

    // completion plus re-reserve on r4, then we0/we1 clash on busy r1
    reserve(4);
    reserve(1);
    idle(); rad[0] = 4; rad[1] = 1; rsv_valid = 1'b1; rsv_ad = 4;
    we1 = 1'b1; wad1 = 4; wd1 = 16'h4444; step();
    idle(); rad[0] = 4; rad[1] = 1; we0 = 1'b1; wad0 = 1; wd0 = 16'h0011;
    we1 = 1'b1; wad1 = 1; wd1 = 16'h0022; step();
    idle(); rad[0] = 4; rad[1] = 1; step();

    // reset mid-run with r3 written and r5 busy
    idle(); we0 = 1'b1; wad0 = 3; wd0 = 16'h1234; step();
    reserve(5);
    async_reset();

    // protocol errors
    idle(); rad[0] = 6; we1 = 1'b1; wad1 = 6; wd1 = 16'h6666; step();
    idle(); rad[0] = 6; step();
    reserve(7);
    idle(); rad[0] = 7; we0 = 1'b1; wad0 = 7; wd0 = 16'h7777; step();
    idle(); rad[0] = 7; rad[1] = 6; step();

    // flush with a simultaneous reserve
    reserve(1);
    reserve(2);
    reserve(3);
    idle(); rad[0] = 1; rad[1] = 2; flush = 1'b1; rsv_valid = 1'b1; rsv_ad = 0; step();
    idle(); rad[0] = 1; rad[1] = 2; step();
    idle(); rad[0] = 3; rad[1] = 7; step();

    // same-cycle write/read of r3 on both ports
    idle(); rad[0] = 3; rad[1] = 3; we0 = 1'b1; wad0 = 3; wd0 = 16'h5A5A; step();
    idle(); rad[0] = 3; rad[1] = 3; step();

    // randomized traffic with periodic resets
    async_reset();
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int i = 0; i < NRD; i++) rad[i] = AW'($urandom_range(DEPTH - 1));
      rsv_valid = 1'($urandom_range(1));
      rsv_ad    = AW'($urandom_range(DEPTH - 1));
      we0  = ($urandom_range(9) < 4);
      wad0 = AW'($urandom_range(DEPTH - 1));
      wd0  = WIDTH'($urandom);
      if (we0 && m_busy[wad0] && $urandom_range(9) != 0) we0 = 1'b0;
      we1  = ($urandom_range(9) < 5);
      wad1 = AW'($urandom_range(DEPTH - 1));
      wd1  = WIDTH'($urandom);
      if (we1 && !m_busy[wad1] && $urandom_range(9) != 0) we1 = 1'b0;
      flush = ($urandom_range(19) == 0);
      step();
      if (c % 100 == 99) async_reset();
    end

    idle();
    @(negedge clk);
    #1;
    chk("queue_drain", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
